// File: rtl/fifo_reader_if.sv
// rtl/fifo_reader_if.sv - FIFO read port and downstream valid/ready stream used by fifo_reader
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4
);
    logic                  empty;
    logic [CNT_WIDTH-1:0]  data_count;
    logic                  rd_ack;
    logic                  rd_err;
    logic [DATA_WIDTH-1:0] d_in;
    logic                  rd_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    // The reader owns rd_en and the downstream stream; FIFO and consumer sit on the slave side.
    modport master (
        input  empty, data_count, rd_ack, rd_err, d_in, m_ready,
        output rd_en, m_valid, m_data
    );
    modport slave (
        output empty, data_count, rd_ack, rd_err, d_in, m_ready,
        input  rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read controller with 2-entry skid buffer; FIFO_READER_WORDCNT_EN adds a delivered-word counter
module fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          clr_err,
    output logic [1:0]    state,
    output logic [15:0]   word_cnt,
    fifo_reader_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_STALL  = 2'b10,
        ST_ERROR  = 2'b11
    } state_t;

    state_t                cur_state;
    state_t                nxt_state;
    logic [1:0]            skid_count;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] skid_head;
    logic [DATA_WIDTH-1:0] skid_tail;
    logic                  pop;
    logic                  push;
    logic                  err_cond;
    logic [2:0]            occupancy;
    logic                  unused_data_count;

    assign pop       = bus.m_valid & bus.m_ready;
    // Words already buffered or on their way, after this cycle's pop; never exceed the 2 skid slots.
    assign occupancy = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
    assign bus.rd_en = reset_n & en & ~bus.empty & (cur_state != ST_ERROR) & (occupancy < 3'd2);
    assign push      = bus.rd_ack & ((skid_count != 2'd2) | pop);
    assign err_cond  = bus.rd_err | (bus.rd_ack & ~inflight);

    assign bus.m_valid       = (skid_count != 2'd0);
    assign bus.m_data        = skid_head;
    assign state             = cur_state;
    assign unused_data_count = ^bus.data_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_count <= 2'd0;
            inflight   <= 1'b0;
            skid_head  <= '0;
            skid_tail  <= '0;
        end else begin
            inflight <= bus.rd_en;
            case ({push, pop})
                2'b10: begin
                    if (skid_count == 2'd0) skid_head <= bus.d_in;
                    else                    skid_tail <= bus.d_in;
                    skid_count <= skid_count + 2'd1;
                end
                2'b01: begin
                    skid_head  <= skid_tail;
                    skid_count <= skid_count - 2'd1;
                end
                2'b11: begin
                    if (skid_count == 2'd1) begin
                        skid_head <= bus.d_in;
                    end else begin
                        skid_head <= skid_tail;
                        skid_tail <= bus.d_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur_state <= ST_IDLE;
        else          cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (err_cond) begin
            nxt_state = ST_ERROR;
        end else if (cur_state == ST_ERROR) begin
            if (clr_err) nxt_state = ST_IDLE;
        end else if ((skid_count == 2'd2) && !bus.m_ready) begin
            nxt_state = ST_STALL;
        end else if (bus.rd_en || (skid_count != 2'd0)) begin
            nxt_state = ST_ACTIVE;
        end else begin
            nxt_state = ST_IDLE;
        end
    end

`ifdef FIFO_READER_WORDCNT_EN
    logic [15:0] word_cnt_q;

    // Survives clr_err on purpose: only reset clears the delivered count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  word_cnt_q <= 16'd0;
        else if (pop)  word_cnt_q <= word_cnt_q + 16'd1;
    end

    assign word_cnt = word_cnt_q;
`else
    assign word_cnt = 16'd0;
`endif

endmodule
